// File: rtl/led_pkg.sv
// led_pkg: shared definitions for the LED fade stage.
//
// Holds the default channel count and brightness resolution, the level type
// for the default resolution, and the matching full-brightness constant.
// The fade logic itself is width-parameterized; level_t and LVL_MAX describe
// the default build and give other blocks a common name for a brightness value.
package led_pkg;

  localparam int unsigned N_LED_DEF    = 10;
  localparam int unsigned PWM_BITS_DEF = 8;

  typedef logic [PWM_BITS_DEF-1:0] level_t;

  // Full brightness: the level a channel snaps to while its pattern bit is set.
  localparam level_t LVL_MAX = '1;

  // Full-scale level for an arbitrary resolution (used for parameter checks).
  function automatic int unsigned level_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/led_fade_ch.sv
// led_fade_ch: one LED channel of the fade stage.
//
// Holds the channel brightness level and turns it into a PWM pin.
//   clk        system clock
//   rst        asynchronous active-high reset, clears level and pin
//   load       pattern bit for this LED; forces full brightness while high
//   decay_tick one-cycle strobe; level drops by DECAY_STEP (floor 0)
//   pwm_cnt    shared free-running PWM counter
//   pin        registered PWM output
module led_fade_ch
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS   = PWM_BITS_DEF,
  parameter int unsigned DECAY_STEP = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                decay_tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                pin
);

  localparam logic [PWM_BITS-1:0] MAX  = '1;
  localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(DECAY_STEP);

  logic [PWM_BITS-1:0] level_q, level_d;
  logic                pin_q, pin_d;

  always_comb begin
    level_d = level_q;
    // Load wins over a coincident decay tick so the head LED never dims.
    if (load) begin
      level_d = MAX;
    end else if (decay_tick) begin
      level_d = (level_q > STEP) ? (level_q - STEP) : '0;
    end
  end

  // MAX is forced solid: pwm_cnt < MAX alone would leave one dark cycle
  // per PWM period. Uses the current level, so a new level reaches the pin
  // one cycle after the level register takes it.
  always_comb begin
    pin_d = (level_q == MAX) | (pwm_cnt < level_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
      pin_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      pin_q   <= pin_d;
    end
  end

  assign pin = pin_q;

endmodule

// File: rtl/led_fade.sv
// led_fade: per-LED PWM fade stage behind the LED chaser.
//
// Each LED jumps to full brightness while its pattern bit is high and then
// fades linearly to off, one DECAY_STEP per decay tick, leaving a comet
// tail behind the moving dot.
//   clk      50 MHz system clock
//   rst      asynchronous active-high reset, clears all state
//   pat_in   N_LED-bit pattern from the chaser, sampled every cycle
//   led_pin  N_LED registered PWM outputs to the board LEDs
module led_fade
  import led_pkg::*;
#(
  parameter int unsigned N_LED      = N_LED_DEF,
  parameter int unsigned PWM_BITS   = PWM_BITS_DEF,
  parameter int unsigned DECAY_DIV  = 195_313,
  parameter int unsigned DECAY_STEP = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_LED-1:0] pat_in,
  output logic [N_LED-1:0] led_pin
);

  localparam int unsigned DIV_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  if (DECAY_STEP < 1 || DECAY_STEP > level_max(PWM_BITS) || DECAY_DIV < 1) begin : g_param_err
    $error("led_fade: DECAY_STEP must be 1..2^PWM_BITS-1 and DECAY_DIV >= 1");
  end

  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                decay_tick;

  // Tick is decoded from the counter state, so the first tick after reset
  // lands on the DECAY_DIV-th edge after release.
  assign decay_tick = (div_cnt_q == DIV_W'(DECAY_DIV - 1));

  always_comb begin
    div_cnt_d = decay_tick ? '0 : div_cnt_q + 1'b1;
    pwm_cnt_d = pwm_cnt_q + 1'b1;  // natural wrap at 2^PWM_BITS
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      pwm_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  for (genvar i = 0; i < N_LED; i++) begin : g_ch
    led_fade_ch #(
      .PWM_BITS   (PWM_BITS),
      .DECAY_STEP (DECAY_STEP)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .load       (pat_in[i]),
      .decay_tick (decay_tick),
      .pwm_cnt    (pwm_cnt_q),
      .pin        (led_pin[i])
    );
  end

endmodule

// File: tb/tb_led_fade.sv
module tb_led_fade;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] pat_in, pat2;
  logic [9:0] led_pin, led_pin2;

  always #10 clk = ~clk;

  // Main DUT: fast decay so whole fades fit in a few dozen cycles.
  led_fade #(.N_LED(10), .PWM_BITS(8), .DECAY_DIV(4), .DECAY_STEP(64)) dut (
    .clk(clk), .rst(rst), .pat_in(pat_in), .led_pin(led_pin));

  // Slow-decay DUT: levels stay frozen long enough to measure PWM duty.
  led_fade #(.N_LED(10), .PWM_BITS(8), .DECAY_DIV(1000), .DECAY_STEP(64)) dut2 (
    .clk(clk), .rst(rst), .pat_in(pat2), .led_pin(led_pin2));

  logic [9:0][7:0] lv;
  logic [7:0]      lv2_0;
  assign lv[0] = dut.g_ch[0].u_ch.level_q;
  assign lv[1] = dut.g_ch[1].u_ch.level_q;
  assign lv[2] = dut.g_ch[2].u_ch.level_q;
  assign lv[3] = dut.g_ch[3].u_ch.level_q;
  assign lv[4] = dut.g_ch[4].u_ch.level_q;
  assign lv[5] = dut.g_ch[5].u_ch.level_q;
  assign lv[6] = dut.g_ch[6].u_ch.level_q;
  assign lv[7] = dut.g_ch[7].u_ch.level_q;
  assign lv[8] = dut.g_ch[8].u_ch.level_q;
  assign lv[9] = dut.g_ch[9].u_ch.level_q;
  assign lv2_0 = dut2.g_ch[0].u_ch.level_q;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [9:0] pat;
    int         n;
    logic [7:0] lv0;
    logic [7:0] lv3;
    logic [9:0] pin;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Edge numbers in comments count from reset release; pwm_cnt == edge.
    tbl.push_back('{10'h001,  1, 8'd255, 8'd0,   10'h000}); // e1  loaded, pin lags
    tbl.push_back('{10'h001,  1, 8'd255, 8'd0,   10'h001}); // e2  pin on
    tbl.push_back('{10'h001, 18, 8'd255, 8'd0,   10'h001}); // e20 load beats tick
    tbl.push_back('{10'h000,  3, 8'd255, 8'd0,   10'h001}); // e23 hold until tick
    tbl.push_back('{10'h000,  1, 8'd191, 8'd0,   10'h001}); // e24
    tbl.push_back('{10'h000,  4, 8'd127, 8'd0,   10'h001}); // e28
    tbl.push_back('{10'h000,  4, 8'd63,  8'd0,   10'h001}); // e32
    tbl.push_back('{10'h000,  3, 8'd63,  8'd0,   10'h001}); // e35
    tbl.push_back('{10'h000,  1, 8'd0,   8'd0,   10'h001}); // e36 saturate at 0
    tbl.push_back('{10'h000,  1, 8'd0,   8'd0,   10'h000}); // e37
    tbl.push_back('{10'h000,  3, 8'd0,   8'd0,   10'h000}); // e40 tick at 0, no wrap
    tbl.push_back('{10'h008,  1, 8'd0,   8'd255, 10'h000}); // e41
    tbl.push_back('{10'h008,  3, 8'd0,   8'd255, 10'h008}); // e44
    tbl.push_back('{10'h000,  4, 8'd0,   8'd191, 10'h008}); // e48
    tbl.push_back('{10'h000,  8, 8'd0,   8'd63,  10'h008}); // e56
    tbl.push_back('{10'h000,  3, 8'd0,   8'd63,  10'h008}); // e59
    tbl.push_back('{10'h008,  1, 8'd0,   8'd255, 10'h008}); // e60 load+tick at 63
    tbl.push_back('{10'h000,  4, 8'd0,   8'd191, 10'h008}); // e64
    tbl.push_back('{10'h000,  8, 8'd0,   8'd63,  10'h008}); // e72 pwm 71 < 127
    tbl.push_back('{10'h000,  1, 8'd0,   8'd63,  10'h000}); // e73 pwm 72 >= 63
    tbl.push_back('{10'h000,  7, 8'd0,   8'd0,   10'h000}); // e80

    rst = 1'b1; pat_in = '0; pat2 = '0;
    step(3);
    chk("reset_pins", 80'(led_pin), 80'h0);
    chk("reset_levels", lv, 80'h0);
    rst = 1'b0;

    foreach (tbl[k]) begin
      pat_in = tbl[k].pat;
      step(tbl[k].n);
      chk($sformatf("vec%0d_lv0", k), 80'(lv[0]), 80'(tbl[k].lv0));
      chk($sformatf("vec%0d_lv3", k), 80'(lv[3]), 80'(tbl[k].lv3));
      chk($sformatf("vec%0d_pin", k), 80'(led_pin), 80'(tbl[k].pin));
    end

    // Mid-run reset with every level at full brightness.
    pat_in = 10'h3ff;
    step(3);
    chk("all_loaded", lv, {10{8'hff}});
    pat_in = '0;
    step(1);
    rst = 1'b1;
    #2;
    chk("async_rst_pins", 80'(led_pin), 80'h0);
    chk("async_rst_levels", lv, 80'h0);
    step(2);
    rst = 1'b0;
    begin
      int bad = 0;
      for (int c = 0; c < 512; c++) begin
        step(1);
        if (led_pin !== 10'h0) bad++;
      end
      chk("post_rst_dark_cycles", 80'(bad), 80'h0);
    end

    // Chaser: 512 edges since release leaves the divider phase at 0, so each
    // 8-cycle slot spans exactly two ticks.
    for (int s = 0; s < 20; s++) begin
      logic [9:0][7:0] exp_lv;
      int h;
      h = s % 10;
      pat_in = 10'(1 << h);
      step(8);
      exp_lv = '0;
      exp_lv[h] = 8'd255;
      if (s >= 1) exp_lv[(h + 9) % 10] = 8'd127;
      chk($sformatf("chase%0d_levels", s), lv, exp_lv);
      chk($sformatf("chase%0d_head_pin", s), 80'(led_pin[h]), 80'h1);
    end
    pat_in = '0;

    // Duty measurement on the slow-decay instance.
    pat2 = 10'h001;
    step(1);
    chk("slow_load", 80'(lv2_0), 80'd255);
    pat2 = '0;
    for (int p = 0; p < 2; p++) begin
      logic [7:0] target;
      int waited, hi;
      target = (p == 0) ? 8'd127 : 8'd63;
      waited = 0;
      while (lv2_0 != target && waited < 3000) begin
        step(1);
        waited++;
      end
      chk($sformatf("reach_level_%0d", target), 80'(lv2_0), 80'(target));
      hi = 0;
      for (int c = 0; c < 256; c++) begin
        step(1);
        hi += int'(led_pin2[0]);
      end
      chk($sformatf("duty_%0d", target), 80'(hi), 80'(target));
    end
    chk("slow_other_pins", 80'(led_pin2[9:1]), 80'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
